// File: rtl/farrow_nco_ctrl.sv
// Interpolation controller feeding a Farrow interpolator: a modulo-1 NCO
// tags every forwarded sample with mu and flags true resampled outputs.
module farrow_nco_ctrl #(
    parameter int          STROBE_DLY = 4,
    parameter logic [16:0] STEP_RST   = 17'd16384
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable_in,
    input  logic [15:0] data_in,
    input  logic [16:0] step_in,
    input  logic        step_load,
    input  logic        sync_in,
    output logic [15:0] data_out,
    output logic [15:0] mu_out,
    output logic        enable_out,
    output logic        strobe_out
);

    localparam logic [16:0] ONE     = 17'd16384;
    localparam logic [16:0] STEP_HI = 17'd32767;

    logic [16:0] acc_q, acc_d;
    logic [16:0] step_act_q, step_act_d;
    logic [16:0] step_pend_q, step_pend_d;
    logic [15:0] data_q, data_d;
    logic [15:0] mu_q, mu_d;
    logic        en_q;
    logic [16:0] ce;
    logic [16:0] step_clamped;
    logic        strobe_now;

    logic [STROBE_DLY:0] strb_sr_q;
    logic [STROBE_DLY:0] en_sr_q;

    always_comb begin
        ce         = sync_in ? 17'd0 : acc_q;
        strobe_now = (ce < ONE);

        step_clamped = step_in;
        if (step_in < ONE) begin
            step_clamped = ONE;
        end else if (step_in > STEP_HI) begin
            step_clamped = STEP_HI;
        end

        step_pend_d = step_load ? step_clamped : step_pend_q;
        step_act_d  = step_act_q;
        acc_d       = ce;
        data_d      = data_q;
        mu_d        = mu_q;

        if (enable_in) begin
            data_d = data_in;
            if (strobe_now) begin
                // Old step_act drives this update; the pending step takes over
                // only at a strobe so mu never jumps mid-interval.
                acc_d      = ce + step_act_q - ONE;
                mu_d       = {2'b00, ce[13:0]};
                step_act_d = step_pend_d;
            end else begin
                acc_d = ce - ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            step_act_q  <= STEP_RST;
            step_pend_q <= STEP_RST;
            data_q      <= '0;
            mu_q        <= '0;
            en_q        <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            step_act_q  <= step_act_d;
            step_pend_q <= step_pend_d;
            data_q      <= data_d;
            mu_q        <= mu_d;
            en_q        <= enable_in;
        end
    end

    // Stage 0 lines up with enable_out; the tail lines up with the Farrow output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            strb_sr_q[0] <= 1'b0;
            en_sr_q[0]   <= 1'b0;
        end else begin
            strb_sr_q[0] <= enable_in & strobe_now;
            en_sr_q[0]   <= enable_in;
        end
    end

    generate
        for (genvar gi = 1; gi <= STROBE_DLY; gi++) begin : g_dly
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    strb_sr_q[gi] <= 1'b0;
                    en_sr_q[gi]   <= 1'b0;
                end else begin
                    strb_sr_q[gi] <= strb_sr_q[gi-1];
                    en_sr_q[gi]   <= en_sr_q[gi-1];
                end
            end
        end
    endgenerate

    assign data_out   = data_q;
    assign mu_out     = mu_q;
    assign enable_out = en_q;
    assign strobe_out = strb_sr_q[STROBE_DLY] & en_sr_q[STROBE_DLY];

endmodule
